triangle_channel: RTL

Parametrised triangle-wave voice: next generation of the channel-3 triangle generator. Owns its phase accumulator, a tick-driven length counter and a play/idle state machine. When a note ends the waveform freezes at its current level, so there is no step back to zero. Sits between the note sequencer (phase delta, length) and the PWM/mixer stage, which consumes `o_output` and `o_frame_pulse`.

---
 rtl/triangle_channel_if.sv | 38 +++
 rtl/triangle_channel.sv | 117 +++++++++++
 2 files changed

// File: rtl/triangle_channel_if.sv
// Sequencer-to-voice bundle for triangle_channel: note load, tick and halt in,
// registered sample, frame pulse and activity flag out.
interface triangle_channel_if #(
    parameter int PHASE_W = 32,
    parameter int LEN_W   = 8,
    parameter int OUT_W   = 9
);
    logic               i_tick_stb;
    logic               i_note_valid;
    logic [PHASE_W-1:0] i_phase_delta;
    logic [LEN_W-1:0]   i_length;
    logic               i_halt;
    logic [OUT_W-1:0]   o_output;
    logic               o_frame_pulse;
    logic               o_active;

    modport master (
        output i_tick_stb,
        output i_note_valid,
        output i_phase_delta,
        output i_length,
        output i_halt,
        input  o_output,
        input  o_frame_pulse,
        input  o_active
    );

    modport slave (
        input  i_tick_stb,
        input  i_note_valid,
        input  i_phase_delta,
        input  i_length,
        input  i_halt,
        output o_output,
        output o_frame_pulse,
        output o_active
    );
endinterface

// File: rtl/triangle_channel.sv
// Triangle-wave voice: phase accumulator, tick-driven length counter and IDLE/PLAY FSM.
// Optional build macro TRIANGLE_CHANNEL_HALT_EN makes i_halt freeze the length counter.
module triangle_channel #(
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 4,
    parameter int OUT_W   = 9,
    parameter int LEN_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    triangle_channel_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phase_nxt_s;
    logic [PHASE_W-1:0] delta_r;
    logic [PHASE_W-1:0] delta_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_nxt_s;
    logic               msb_d_r;
    logic [OUT_W-1:0]   output_r;
    logic               pulse_r;
    logic               active_r;
    logic               tick_en_s;
    logic [AMP_W-1:0]   tri_s;
    logic [AMP_W-1:0]   amp_s;

`ifdef TRIANGLE_CHANNEL_HALT_EN
    assign tick_en_s = bus.i_tick_stb & ~bus.i_halt;
`else
    logic unused_halt_s;
    assign unused_halt_s = bus.i_halt;
    assign tick_en_s     = bus.i_tick_stb;
`endif

    // Fold the upper phase bits into a rising/falling ramp.
    assign tri_s = phase_r[PHASE_W-2 -: AMP_W];
    assign amp_s = phase_r[PHASE_W-1] ? ~tri_s : tri_s;

    // Next-state logic; a note load overrides any coincident tick.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        delta_nxt_s = delta_r;
        len_nxt_s   = len_r;
        if (bus.i_note_valid) begin
            delta_nxt_s = bus.i_phase_delta;
            len_nxt_s   = bus.i_length;
            if (bus.i_length != {LEN_W{1'b0}}) begin
                // Phase carries on from where it was, so reloads never jump.
                state_nxt_s = ST_PLAY;
                phase_nxt_s = phase_r + bus.i_phase_delta;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_PLAY: begin
                    phase_nxt_s = phase_r + delta_r;
                    if (tick_en_s) begin
                        len_nxt_s = len_r - LEN_W'(1);
                        if (len_r == LEN_W'(1)) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_PLAY;
                        end
                    end else begin
                        len_nxt_s = len_r;
                    end
                end
                ST_IDLE: begin
                    len_nxt_s = {LEN_W{1'b0}};
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    len_nxt_s   = {LEN_W{1'b0}};
                end
            endcase
        end
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            phase_r  <= {PHASE_W{1'b0}};
            delta_r  <= {PHASE_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
            msb_d_r  <= 1'b0;
            output_r <= {OUT_W{1'b0}};
            pulse_r  <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            phase_r  <= phase_nxt_s;
            delta_r  <= delta_nxt_s;
            len_r    <= len_nxt_s;
            msb_d_r  <= phase_r[PHASE_W-1];
            output_r <= OUT_W'(amp_s);
            // A crossing made on the final PLAY edge is not reported once frozen.
            pulse_r  <= phase_r[PHASE_W-1] & ~msb_d_r & (state_r == ST_PLAY);
            active_r <= (state_nxt_s == ST_PLAY);
        end
    end

    assign bus.o_output      = output_r;
    assign bus.o_frame_pulse = pulse_r;
    assign bus.o_active      = active_r;

endmodule
